// File: rtl/game_pkg.sv
// game_pkg: values shared between the game state manager and the lock engine.
//   mgr_state_e  : state codes driven by the game state manager (S0..S7)
//   PH_*         : phase codes reported by lock_engine to the display/LED stage
//   DEF_*        : default round sizing and timing
package game_pkg;

   typedef enum logic [3:0] {
      S0 = 4'd0, S1 = 4'd1, S2 = 4'd2, S3 = 4'd3,
      S4 = 4'd4, S5 = 4'd5, S6 = 4'd6, S7 = 4'd7
   } mgr_state_e;

   localparam logic [2:0] PH_IDLE  = 3'd0;
   localparam logic [2:0] PH_CODE  = 3'd1;
   localparam logic [2:0] PH_GUESS = 3'd2;
   localparam logic [2:0] PH_CHECK = 3'd3;
   localparam logic [2:0] PH_WIN   = 3'd4;
   localparam logic [2:0] PH_LOSE  = 3'd5;

   localparam int DEF_NUM_DIGITS    = 4;
   localparam int DEF_MAX_TRIES     = 5;
   localparam int DEF_EXTRA_TRIES   = 2;
   localparam int DEF_GUESS_TIMEOUT = 500000000;  // 10 s at 50 MHz
   localparam int TIMER_W           = 30;

endpackage

// File: rtl/lock_digit_collector.sv
// lock_digit_collector: gathers NUM_DIGITS decimal digits, one per key_enter.
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : synchronous clear of index, digits and bad_digit
//   en         : collector is accepting enters this cycle
//   key_enter  : enter pulse, sw : digit value (0..9 valid)
//   idx        : position the next digit will be written to
//   digits     : stored digits, digits[i] = i-th entered digit
//   bad_digit  : registered one-cycle pulse after an enter with sw > 9
//   done       : combinational, high in the cycle the last digit is stored
module lock_digit_collector #(
   parameter int NUM_DIGITS = 4,
   parameter int IDX_W      = $clog2(NUM_DIGITS)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       clr,
   input  logic                       en,
   input  logic                       key_enter,
   input  logic [3:0]                 sw,
   output logic [IDX_W-1:0]           idx,
   output logic [NUM_DIGITS-1:0][3:0] digits,
   output logic                       bad_digit,
   output logic                       done
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

   logic [IDX_W-1:0]           idx_q, idx_d;
   logic [NUM_DIGITS-1:0][3:0] digits_q, digits_d;
   logic                       bad_q, bad_d;
   logic                       accept, last;

   always_comb begin
      accept   = en & key_enter & (sw <= 4'd9);
      last     = (idx_q == LAST_IDX);
      done     = accept & last;
      idx_d    = idx_q;
      digits_d = digits_q;
      bad_d    = en & key_enter & (sw > 4'd9);
      if (clr) begin
         idx_d    = '0;
         digits_d = '0;
         bad_d    = 1'b0;
      end else if (accept) begin
         digits_d[idx_q] = sw;
         // wrap so the next round of entry starts at position 0
         idx_d = last ? '0 : idx_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idx_q    <= '0;
         digits_q <= '0;
         bad_q    <= 1'b0;
      end else begin
         idx_q    <= idx_d;
         digits_q <= digits_d;
         bad_q    <= bad_d;
      end
   end

   assign idx       = idx_q;
   assign digits    = digits_q;
   assign bad_digit = bad_q;

endmodule

// File: rtl/lock_engine.sv
// lock_engine: "set a lock" round. Coder enters a code, breaker guesses it
// under a per-guess timeout and a try budget.
//   clk, rst_n  : clock, synchronous active-low reset
//   state       : game manager state; S7 starts a round, S0 aborts from anywhere
//   SW          : digit value, key_enter : enter pulse
//   power_flex  : adds EXTRA_TRIES when sampled with the last code digit
//   phase       : PH_IDLE..PH_LOSE
//   digit_idx   : position of next digit (code in CODE, guess otherwise)
//   match_mask  : per-position equality from the last CHECK, hits = popcount
//   tries_left  : remaining guesses
//   bad_digit   : one-cycle pulse after an out-of-range enter
//   win, lose   : high while in WIN / LOSE
module lock_engine
   import game_pkg::*;
#(
   parameter int NUM_DIGITS    = DEF_NUM_DIGITS,
   parameter int MAX_TRIES     = DEF_MAX_TRIES,
   parameter int EXTRA_TRIES   = DEF_EXTRA_TRIES,
   parameter int GUESS_TIMEOUT = DEF_GUESS_TIMEOUT,
   parameter int IDX_W         = $clog2(NUM_DIGITS),
   parameter int HITS_W        = $clog2(NUM_DIGITS + 1),
   parameter int TRIES_W       = $clog2(MAX_TRIES + EXTRA_TRIES + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [3:0]            state,
   input  logic [3:0]            SW,
   input  logic                  key_enter,
   input  logic                  power_flex,
   output logic [2:0]            phase,
   output logic [IDX_W-1:0]      digit_idx,
   output logic [NUM_DIGITS-1:0] match_mask,
   output logic [HITS_W-1:0]     hits,
   output logic [TRIES_W-1:0]    tries_left,
   output logic                  bad_digit,
   output logic                  win,
   output logic                  lose
);

   localparam logic [TIMER_W-1:0] TIMER_LAST  = TIMER_W'(GUESS_TIMEOUT - 1);
   localparam logic [TRIES_W-1:0] TRIES_BASE  = TRIES_W'(MAX_TRIES);
   localparam logic [TRIES_W-1:0] TRIES_EXTRA = TRIES_W'(EXTRA_TRIES);
   localparam logic [TRIES_W-1:0] TRIES_ONE   = TRIES_W'(1);

   logic [2:0]            phase_q, phase_d;
   logic [TIMER_W-1:0]    timer_q, timer_d;
   logic [TRIES_W-1:0]    tries_q, tries_d;
   logic [NUM_DIGITS-1:0] mask_q, mask_d;
   logic [HITS_W-1:0]     hits_q, hits_d;

   logic                       abort, timeout, all_match;
   logic                       code_en, guess_en, guess_clr;
   logic                       code_done, guess_done, code_bad, guess_bad;
   logic [IDX_W-1:0]           code_idx, guess_idx;
   logic [NUM_DIGITS-1:0][3:0] code_digits, guess_digits;
   logic [NUM_DIGITS-1:0]      match_c;
   logic [HITS_W-1:0]          hits_c;

   assign abort   = (state == S0);
   assign timeout = (phase_q == PH_GUESS) && (timer_q == TIMER_LAST);
   // a timeout swallows any enter arriving in the same cycle
   assign code_en   = (phase_q == PH_CODE) && !abort;
   assign guess_en  = (phase_q == PH_GUESS) && !abort && !timeout;
   assign guess_clr = abort || timeout || ((phase_q == PH_CHECK) && !all_match);

   lock_digit_collector #(.NUM_DIGITS(NUM_DIGITS), .IDX_W(IDX_W)) u_code (
      .clk(clk), .rst_n(rst_n), .clr(abort), .en(code_en), .key_enter(key_enter),
      .sw(SW), .idx(code_idx), .digits(code_digits), .bad_digit(code_bad),
      .done(code_done)
   );

   lock_digit_collector #(.NUM_DIGITS(NUM_DIGITS), .IDX_W(IDX_W)) u_guess (
      .clk(clk), .rst_n(rst_n), .clr(guess_clr), .en(guess_en), .key_enter(key_enter),
      .sw(SW), .idx(guess_idx), .digits(guess_digits), .bad_digit(guess_bad),
      .done(guess_done)
   );

   always_comb begin
      match_c = '0;
      hits_c  = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         match_c[i] = (code_digits[i] == guess_digits[i]);
         hits_c     = hits_c + HITS_W'(match_c[i]);
      end
      all_match = &match_c;
   end

   always_comb begin
      phase_d = phase_q;
      timer_d = timer_q;
      tries_d = tries_q;
      mask_d  = mask_q;
      hits_d  = hits_q;
      if (abort) begin
         phase_d = PH_IDLE;
         timer_d = '0;
         tries_d = '0;
         mask_d  = '0;
         hits_d  = '0;
      end else begin
         case (phase_q)
            PH_IDLE: if (state == S7) phase_d = PH_CODE;
            PH_CODE: if (code_done) begin
               phase_d = PH_GUESS;
               timer_d = '0;
               tries_d = TRIES_BASE + (power_flex ? TRIES_EXTRA : '0);
            end
            PH_GUESS: begin
               if (timeout) begin
                  timer_d = '0;
                  if (tries_q != '0) tries_d = tries_q - 1'b1;
                  if (tries_q == TRIES_ONE) phase_d = PH_LOSE;
               end else if (guess_done) begin
                  timer_d = '0;
                  phase_d = PH_CHECK;
               end else begin
                  timer_d = timer_q + 1'b1;
               end
            end
            PH_CHECK: begin
               mask_d = match_c;
               hits_d = hits_c;
               if (all_match) begin
                  phase_d = PH_WIN;
               end else begin
                  if (tries_q != '0) tries_d = tries_q - 1'b1;
                  phase_d = (tries_q == TRIES_ONE) ? PH_LOSE : PH_GUESS;
                  timer_d = '0;
               end
            end
            PH_WIN, PH_LOSE: ;
            default: phase_d = PH_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         phase_q <= PH_IDLE;
         timer_q <= '0;
         tries_q <= '0;
         mask_q  <= '0;
         hits_q  <= '0;
      end else begin
         phase_q <= phase_d;
         timer_q <= timer_d;
         tries_q <= tries_d;
         mask_q  <= mask_d;
         hits_q  <= hits_d;
      end
   end

   assign phase      = phase_q;
   assign digit_idx  = (phase_q == PH_CODE) ? code_idx : guess_idx;
   assign match_mask = mask_q;
   assign hits       = hits_q;
   assign tries_left = tries_q;
   assign bad_digit  = code_bad | guess_bad;
   assign win        = (phase_q == PH_WIN);
   assign lose       = (phase_q == PH_LOSE);

endmodule

// File: tb/tb_lock_engine.sv
// tb_lock_engine: randomized and directed scenarios for lock_engine, checked
// against expectations derived from the round rules (tries budget, per-digit
// equality, timeout length) rather than from the design's internals.
module tb_lock_engine;

   localparam int TO = 20;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] state = 4'd0;
   logic [3:0] SW = 4'd0;
   logic       key_enter = 1'b0;
   logic       power_flex = 1'b0;
   logic [2:0] phase;
   logic [1:0] digit_idx;
   logic [3:0] match_mask;
   logic [2:0] hits;
   logic [2:0] tries_left;
   logic       bad_digit, win, lose;

   int checks = 0;
   int errors = 0;

   lock_engine #(.NUM_DIGITS(4), .MAX_TRIES(5), .EXTRA_TRIES(2), .GUESS_TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .state(state), .SW(SW), .key_enter(key_enter),
      .power_flex(power_flex), .phase(phase), .digit_idx(digit_idx),
      .match_mask(match_mask), .hits(hits), .tries_left(tries_left),
      .bad_digit(bad_digit), .win(win), .lose(lose)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // expected output tuple: {phase, idx, mask, hits, tries, bad, win, lose}
   function automatic logic [17:0] pk(input logic [2:0] ph, input logic [1:0] idx,
                                      input logic [3:0] m, input logic [2:0] h,
                                      input logic [2:0] t, input logic b);
      return {ph, idx, m, h, t, b, ph == 3'd4, ph == 3'd5};
   endfunction

   function automatic logic [17:0] obs();
      return {phase, digit_idx, match_mask, hits, tries_left, bad_digit, win, lose};
   endfunction

   function automatic logic [3:0] cmp(input logic [3:0][3:0] c, input logic [3:0][3:0] g);
      logic [3:0] m;
      for (int i = 0; i < 4; i++) m[i] = (c[i] == g[i]);
      return m;
   endfunction

   function automatic logic [2:0] ones(input logic [3:0] m);
      int n = 0;
      for (int i = 0; i < 4; i++) n += int'(m[i]);
      return 3'(n);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic enter(input logic [3:0] d);
      SW = d;
      key_enter = 1'b1;
      tick();
      key_enter = 1'b0;
   endtask

   task automatic abort_round();
      state = 4'd0;
      tick();
   endtask

   // power_flex is noise except on the last code digit
   task automatic start_round(input logic [3:0][3:0] c, input logic flex);
      state = 4'd7;
      tick();
      for (int i = 0; i < 4; i++) begin
         power_flex = (i == 3) ? flex : 1'($urandom_range(0, 1));
         enter(c[i]);
      end
      power_flex = 1'($urandom_range(0, 1));
      tick();  // one idle GUESS cycle; flex noise must not matter now
      power_flex = 1'b0;
   endtask

   task automatic play(input logic [3:0][3:0] g);
      for (int i = 0; i < 4; i++) enter(g[i]);
   endtask

   task automatic test_reset();
      logic [17:0] e;
      rst_n = 1'b0;
      state = 4'd7;
      tick();
      tick();
      e = pk(3'd0, 2'd0, 4'd0, 3'd0, 3'd0, 1'b0);
      checks++;
      if (obs() !== e) begin errors++; $display("FAIL reset: got %h want %h", obs(), e); end
      rst_n = 1'b1;
      state = 4'd0;
      tick();
   endtask

   task automatic test_win();
      logic [17:0] e;
      start_round({4'd4, 4'd3, 4'd2, 4'd1}, 1'b0);
      e = pk(3'd2, 2'd0, 4'd0, 3'd0, 3'd5, 1'b0);
      checks++;
      if (obs() !== e) begin errors++; $display("FAIL win_guess_entry: got %h want %h", obs(), e); end
      play({4'd4, 4'd3, 4'd2, 4'd1});
      e = pk(3'd3, 2'd0, 4'd0, 3'd0, 3'd5, 1'b0);
      checks++;
      if (obs() !== e) begin errors++; $display("FAIL win_check: got %h want %h", obs(), e); end
      tick();
      e = pk(3'd4, 2'd0, 4'hF, 3'd4, 3'd5, 1'b0);
      checks++;
      if (obs() !== e) begin errors++; $display("FAIL win_result: got %h want %h", obs(), e); end
      enter(4'd2);
      enter(4'd13);
      checks++;
      if (obs() !== e) begin errors++; $display("FAIL win_hold: got %h want %h", obs(), e); end
      abort_round();
   endtask

   task automatic test_partial();
      logic [17:0] e;
      start_round({4'd7, 4'd0, 4'd0, 4'd9}, 1'b0);
      play({4'd0, 4'd7, 4'd0, 4'd9});
      tick();
      e = pk(3'd2, 2'd0, 4'b0011, 3'd2, 3'd4, 1'b0);
      checks++;
      if (obs() !== e) begin errors++; $display("FAIL partial: got %h want %h", obs(), e); end
      abort_round();
   endtask

   task automatic test_flex_lose();
      logic [17:0] e;
      logic [3:0][3:0] c = {4'd8, 4'd6, 4'd4, 4'd2};
      logic [3:0][3:0] g = {4'd9, 4'd7, 4'd5, 4'd3};
      start_round(c, 1'b1);
      e = pk(3'd2, 2'd0, 4'd0, 3'd0, 3'd7, 1'b0);
      checks++;
      if (obs() !== e) begin errors++; $display("FAIL flex_budget: got %h want %h", obs(), e); end
      for (int k = 1; k <= 7; k++) begin
         play(g);
         tick();
         e = pk((k == 7) ? 3'd5 : 3'd2, 2'd0, 4'd0, 3'd0, 3'(7 - k), 1'b0);
         checks++;
         if (obs() !== e) begin errors++; $display("FAIL flex_step%0d: got %h want %h", k, obs(), e); end
      end
      enter(4'd12);
      enter(4'd8);
      checks++;
      if (obs() !== e) begin errors++; $display("FAIL lose_hold: got %h want %h", obs(), e); end
      abort_round();
   endtask

   task automatic test_timeout();
      logic [17:0] e;
      logic [3:0][3:0] c = {4'd1, 4'd5, 4'd3, 4'd6};
      start_round(c, 1'b0);  // one of TO cycles already spent
      enter(4'd6);
      enter(4'd3);
      repeat (TO - 4) tick();
      e = pk(3'd2, 2'd2, 4'd0, 3'd0, 3'd5, 1'b0);
      checks++;
      if (obs() !== e) begin errors++; $display("FAIL timeout_before: got %h want %h", obs(), e); end
      enter(4'd5);  // lands on the timeout cycle and is dropped
      e = pk(3'd2, 2'd0, 4'd0, 3'd0, 3'd4, 1'b0);
      checks++;
      if (obs() !== e) begin errors++; $display("FAIL timeout_hit: got %h want %h", obs(), e); end
      play(c);
      tick();
      e = pk(3'd4, 2'd0, 4'hF, 3'd4, 3'd4, 1'b0);
      checks++;
      if (obs() !== e) begin errors++; $display("FAIL timeout_then_win: got %h want %h", obs(), e); end
      abort_round();
      start_round(c, 1'b0);
      repeat (5 * TO - 2) tick();
      e = pk(3'd2, 2'd0, 4'd0, 3'd0, 3'd1, 1'b0);
      checks++;
      if (obs() !== e) begin errors++; $display("FAIL timeout_last_try: got %h want %h", obs(), e); end
      tick();
      e = pk(3'd5, 2'd0, 4'd0, 3'd0, 3'd0, 1'b0);
      checks++;
      if (obs() !== e) begin errors++; $display("FAIL timeout_lose: got %h want %h", obs(), e); end
      abort_round();
   endtask

   task automatic test_bad_digit();
      logic [17:0] e;
      enter(4'd12);
      e = pk(3'd0, 2'd0, 4'd0, 3'd0, 3'd0, 1'b0);
      checks++;
      if (obs() !== e) begin errors++; $display("FAIL bad_in_idle: got %h want %h", obs(), e); end
      state = 4'd7;
      tick();
      enter(4'd3);
      enter(4'd12);
      e = pk(3'd1, 2'd1, 4'd0, 3'd0, 3'd0, 1'b1);
      checks++;
      if (obs() !== e) begin errors++; $display("FAIL bad_in_code: got %h want %h", obs(), e); end
      tick();
      e = pk(3'd1, 2'd1, 4'd0, 3'd0, 3'd0, 1'b0);
      checks++;
      if (obs() !== e) begin errors++; $display("FAIL bad_pulse_end: got %h want %h", obs(), e); end
      enter(4'd4);
      enter(4'd5);
      enter(4'd6);
      enter(4'd10);
      e = pk(3'd2, 2'd0, 4'd0, 3'd0, 3'd5, 1'b1);
      checks++;
      if (obs() !== e) begin errors++; $display("FAIL bad_in_guess: got %h want %h", obs(), e); end
      abort_round();
   endtask

   task automatic test_abort();
      logic [17:0] e;
      logic [17:0] z = pk(3'd0, 2'd0, 4'd0, 3'd0, 3'd0, 1'b0);
      logic [3:0][3:0] c = {4'd5, 4'd5, 4'd5, 4'd5};
      start_round(c, 1'b0);
      play({4'd1, 4'd1, 4'd1, 4'd5});
      tick();
      e = pk(3'd2, 2'd0, 4'b0001, 3'd1, 3'd4, 1'b0);
      checks++;
      if (obs() !== e) begin errors++; $display("FAIL abort_setup: got %h want %h", obs(), e); end
      enter(4'd5);
      enter(4'd5);
      abort_round();
      checks++;
      if (obs() !== z) begin errors++; $display("FAIL abort_guess: got %h want %h", obs(), z); end
      start_round(c, 1'b0);
      play(c);
      tick();
      abort_round();
      checks++;
      if (obs() !== z) begin errors++; $display("FAIL abort_win: got %h want %h", obs(), z); end
      start_round(c, 1'b0);
      play({4'd0, 4'd0, 4'd0, 4'd0});
      rst_n = 1'b0;  // state stays S7: reset must still win
      tick();
      rst_n = 1'b1;
      checks++;
      if (obs() !== z) begin errors++; $display("FAIL reset_in_check: got %h want %h", obs(), z); end
      abort_round();
   endtask

   task automatic test_random();
      logic [17:0] e;
      logic [3:0][3:0] c, g;
      logic [3:0] m, pm;
      logic flex;
      int t;
      bit done;
      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < 4; i++) c[i] = 4'($urandom_range(0, 9));
         flex = 1'($urandom_range(0, 1));
         start_round(c, flex);
         t = flex ? 7 : 5;
         pm = 4'd0;
         done = 1'b0;
         while (!done) begin
            for (int i = 0; i < 4; i++)
               g[i] = ($urandom_range(0, 1) == 0) ? c[i] : 4'($urandom_range(0, 9));
            if ($urandom_range(0, 5) == 0) g = c;
            play(g);
            e = pk(3'd3, 2'd0, pm, ones(pm), 3'(t), 1'b0);
            checks++;
            if (obs() !== e) begin errors++; $display("FAIL rnd%0d_check: got %h want %h", r, obs(), e); end
            tick();
            m = cmp(c, g);
            if (m == 4'hF) begin
               e = pk(3'd4, 2'd0, m, 3'd4, 3'(t), 1'b0);
               done = 1'b1;
            end else begin
               t--;
               e = pk((t == 0) ? 3'd5 : 3'd2, 2'd0, m, ones(m), 3'(t), 1'b0);
               done = (t == 0);
            end
            checks++;
            if (obs() !== e) begin errors++; $display("FAIL rnd%0d_result: got %h want %h", r, obs(), e); end
            pm = m;
         end
         abort_round();
      end
   endtask

   initial begin
      test_reset();
      test_win();
      test_partial();
      test_flex_lose();
      test_timeout();
      test_bad_digit();
      test_abort();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
